bsg_zynq_axil_master: RTL and testbench

BSG_ZYNQ_AXIL_MASTER -- requirements
Module: bsg_zynq_axil_master
Interface
REQ-001 C_M_AXI_DATA_WIDTH, 32, data width of the AXI4-Lite bus and of the command/response data.
REQ-002 C_M_AXI_ADDR_WIDTH, 6, byte address width of the AXI4-Lite bus.
REQ-003 aclk  in  1  sole clock; all logic samples on its rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 cmd_v_i  in  1  command valid.
REQ-006 cmd_ready_o  out  1  block accepts a command this cycle.
REQ-007 cmd_write_i  in  1  1 = write, 0 = read.
REQ-008 cmd_addr_i  in  ADDR  target byte address.
REQ-009 cmd_data_i  in  DATA  write data; ignored for reads.
REQ-010 cmd_wstrb_i  in  DATA/8  write byte strobes.
REQ-011 resp_v_o  out  1  response valid.
REQ-012 resp_yumi_i  in  1  consumer takes the response.
REQ-013 resp_write_o  out  1  response belongs to a write.
REQ-014 resp_data_o  out  DATA  read data; 0 for writes.
REQ-015 resp_err_o  out  1  bit 1 of the captured BRESP/RRESP (SLVERR or DECERR).
REQ-016 m_axi_awaddr/awvalid  out  ADDR/1, with m_axi_awready  in  1: write-address channel.
REQ-017 m_axi_wdata/wstrb/wvalid  out  DATA/DATA/8/1, with m_axi_wready  in  1: write-data channel.
REQ-018 m_axi_bresp/bvalid  in  2/1, with m_axi_bready  out  1: write-response channel.
REQ-019 m_axi_araddr/arvalid  out  ADDR/1, with m_axi_arready  in  1: read-address channel.
REQ-020 m_axi_rdata/rresp/rvalid  in  DATA/2/1, with m_axi_rready  out  1: read-data channel.
REQ-021 m_axi_awprot, m_axi_arprot  out  3  both driven 3'b000.
Function
REQ-022 FSM states: IDLE, WR (AW and/or W pending), BRESP, AR, RDATA, RESP; the block allows one outstanding transaction.
REQ-023 cmd_ready_o = (state == IDLE), registered; handshake cmd_v_i & cmd_ready_o latches write, addr, data and strobes, then moves to WR or AR.
REQ-024 m_axi_awvalid and m_axi_wvalid rise together the cycle after a write is accepted; each drops the cycle after its own handshake, so AW and W complete in either order or in the same cycle.
REQ-025 No AXI valid drops before its ready; addr/data/strb stay constant while valid is high.
REQ-026 When both AW and W have completed, go to BRESP with m_axi_bready = 1; on m_axi_bvalid, capture bresp and go to RESP.
REQ-027 After a read is accepted, m_axi_arvalid rises the next cycle until m_axi_arready; then RDATA with m_axi_rready = 1; on m_axi_rvalid, capture rdata/rresp and go to RESP.
REQ-028 In RESP, resp_v_o = 1 and response fields are held stable until resp_yumi_i; yumi returns to IDLE, with cmd_ready_o = 1 the next cycle; resp_yumi_i is ignored when resp_v_o = 0.
REQ-029 Minimum latency with an always-ready slave: accept at cycle 0, AW/W valid at 1, bready at 2, resp_v_o at 3; same for reads via AR/R.
REQ-030 No combinational path from any input to any output; cmd_v_i while busy has no effect.
Reset
REQ-031 Asserting aresetn low asynchronously forces IDLE and sets all AXI valid/ready outputs, resp_v_o, cmd_ready_o and all data registers to 0; cmd_ready_o rises on the first clock after release.
REQ-032 Reset mid-transaction abandons the transaction: no response and no later AXI beat is issued for it.
Structure
REQ-033 bsg_zynq_axil_pkg holds the FSM state enum and the AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-034 Single flat module, no sub-module; the standard cosim AXI-Lite slave shell serves as the bench responder.
Verification
REQ-035 Write addr 0x10 data 0xDEADBEEF strb 0xF, slave always ready, BRESP OKAY -> resp_v_o at cycle 3, resp_write_o = 1, resp_err_o = 0, resp_data_o = 0.
REQ-036 Write with awready delayed 3 cycles after wready -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one response.
REQ-037 Read addr 0x08, slave returns 0x12345678 with RRESP SLVERR after 2 stall cycles -> resp_data_o = 0x12345678, resp_err_o = 1.
REQ-038 Response held 5 cycles without yumi -> cmd_ready_o = 0 throughout and fields stable; yumi -> cmd_ready_o = 1 next cycle.
REQ-039 aresetn asserted while awvalid high -> all outputs 0 immediately, no resp_v_o, next command completes normally.

---
 rtl/bsg_zynq_axil_pkg.sv | 22 ++
 rtl/bsg_zynq_axil_master.sv | 144 ++++++++++++++
 tb/tb_bsg_zynq_axil_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_zynq_axil_pkg.sv
// rtl/bsg_zynq_axil_pkg.sv - state encodings and AXI response codes for the AXI4-Lite master
package bsg_zynq_axil_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WR    = 3'd1;
  localparam state_t ST_BRESP = 3'd2;
  localparam state_t ST_AR    = 3'd3;
  localparam state_t ST_RDATA = 3'd4;
  localparam state_t ST_RESP  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/bsg_zynq_axil_master.sv
// rtl/bsg_zynq_axil_master.sv - single-outstanding AXI4-Lite master driven by a command/response handshake
module bsg_zynq_axil_master
  import bsg_zynq_axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6
) (
  input  logic                            aclk,
  input  logic                            aresetn,

  input  logic                            cmd_v_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_write_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data_i,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,

  output logic                            resp_v_o,
  input  logic                            resp_yumi_i,
  output logic                            resp_write_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   resp_data_o,
  output logic                            resp_err_o,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,

  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,

  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;

  assign m_axi_awaddr = addr_r;
  assign m_axi_araddr = addr_r;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // Every output is a flop so nothing combinationally follows an input.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      cmd_ready_o   <= 1'b0;
      addr_r        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      resp_v_o      <= 1'b0;
      resp_write_o  <= 1'b0;
      resp_data_o   <= '0;
      resp_err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_v_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            addr_r      <= cmd_addr_i;
            m_axi_wdata <= cmd_data_i;
            m_axi_wstrb <= cmd_wstrb_i;
            if (cmd_write_i) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= ST_AR;
            end
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          // AW and W retire independently; move on once neither is still pending.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= ST_BRESP;
          end
        end
        ST_BRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp_v_o     <= 1'b1;
            resp_write_o <= 1'b1;
            resp_data_o  <= '0;
            resp_err_o   <= resp_is_err(m_axi_bresp);
            state        <= ST_RESP;
          end
        end
        ST_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            resp_v_o     <= 1'b1;
            resp_write_o <= 1'b0;
            resp_data_o  <= m_axi_rdata;
            resp_err_o   <= resp_is_err(m_axi_rresp);
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_yumi_i) begin
            resp_v_o    <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_zynq_axil_master.sv
// tb/tb_bsg_zynq_axil_master.sv - scoreboard bench for bsg_zynq_axil_master with a scripted AXI-Lite slave
module tb_bsg_zynq_axil_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_v_i, cmd_ready_o, cmd_write_i;
  logic [5:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [3:0]  cmd_wstrb_i;
  logic        resp_v_o, resp_yumi_i, resp_write_o, resp_err_o;
  logic [31:0] resp_data_o;
  logic [5:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  bsg_zynq_axil_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_wstrb_i(cmd_wstrb_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_write_o(resp_write_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        write;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
  endtask

  // Drives a command and returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    @(negedge aclk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check_eq("cmd_ready_wait", cmd_ready_o, 1);
    cmd_v_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_data_i = d; cmd_wstrb_i = s;
    @(posedge aclk);
    @(negedge aclk);
    cmd_v_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0; cmd_wstrb_i = '0;
    check_eq("cmd_ready_busy", cmd_ready_o, 0);
  endtask

  task automatic run_txn(input logic wr, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw_dly, input int w_dly,
                         input int ar_dly, input int r_dly, input logic [1:0] rsp,
                         input logic [31:0] rdata, input int hold);
    bit a_done = 0, w_done = 0, b_done = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0;
    int stall = 0, aw_hi = 0, w_hi = 0, resp_k = -1, exp_k;
    exp_t e, got;
    logic [34:0] held;
    send_cmd(wr, a, d, s);
    sb.push_back('{write: wr, data: (wr ? 32'h0 : rdata), err: rsp[1]});
    for (int k = 0; k < 200; k++) begin
      if (resp_v_o) begin
        resp_k = k;
        break;
      end
      if (aw_pend) check_eq("awvalid_held", m_axi_awvalid, 1);
      if (w_pend)  check_eq("wvalid_held", m_axi_wvalid, 1);
      if (ar_pend) check_eq("arvalid_held", m_axi_arvalid, 1);
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid)  w_hi++;
      m_axi_awready = (k >= aw_dly);
      m_axi_wready  = (k >= w_dly);
      m_axi_arready = (k >= ar_dly);
      m_axi_bvalid  = 1'b0;
      m_axi_rvalid  = 1'b0;
      if (wr && a_done && w_done && !b_done) begin
        m_axi_bvalid = (stall >= r_dly);
        m_axi_bresp  = rsp;
        stall++;
      end
      if (!wr && a_done && !b_done) begin
        m_axi_rvalid = (stall >= r_dly);
        m_axi_rresp  = rsp;
        m_axi_rdata  = m_axi_rvalid ? rdata : 32'hBAD0_BAD0;
        stall++;
      end
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend  = m_axi_wvalid && !m_axi_wready;
      ar_pend = m_axi_arvalid && !m_axi_arready;
      if (m_axi_awvalid && m_axi_awready) begin
        check_eq("awaddr", m_axi_awaddr, a);
        a_done = 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check_eq("wdata_wstrb", {m_axi_wstrb, m_axi_wdata}, {s, d});
        w_done = 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        check_eq("araddr", m_axi_araddr, a);
        a_done = 1;
      end
      if ((m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready)) b_done = 1;
      @(posedge aclk);
      @(negedge aclk);
    end
    slave_idle();
    check_eq("resp_timeout", resp_k >= 0, 1);
    e = sb.pop_front();
    if (resp_k < 0) return;
    exp_k = (wr ? ((aw_dly > w_dly) ? aw_dly : w_dly) : ar_dly) + 2 + r_dly;
    check_eq("resp_latency", resp_k + 1, exp_k + 1);
    if (wr) begin
      check_eq("awvalid_cycles", aw_hi, aw_dly + 1);
      check_eq("wvalid_cycles", w_hi, w_dly + 1);
    end
    held = {resp_write_o, resp_err_o, resp_data_o};
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_ready_low", {cmd_ready_o, resp_v_o}, 2'b01);
      check_eq("hold_stable", {resp_write_o, resp_err_o, resp_data_o}, held);
      @(posedge aclk);
      @(negedge aclk);
    end
    got = '{write: resp_write_o, data: resp_data_o, err: resp_err_o};
    check_eq("resp_fields", got, e);
    resp_yumi_i = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    resp_yumi_i = 1'b0;
    check_eq("after_yumi", {cmd_ready_o, resp_v_o}, 2'b10);
  endtask

  initial begin
    aresetn = 1'b0; cmd_v_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_data_i = '0; cmd_wstrb_i = '0; resp_yumi_i = 1'b0;
    slave_idle();
    repeat (3) @(negedge aclk);
    check_eq("reset_outputs",
             {cmd_ready_o, resp_v_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
              m_axi_arvalid, m_axi_rready, m_axi_awprot, m_axi_arprot}, '0);
    check_eq("reset_data", {resp_data_o, m_axi_wdata, m_axi_awaddr}, '0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("ready_after_reset", cmd_ready_o, 1);
    resp_yumi_i = 1'b1;
    @(negedge aclk);
    resp_yumi_i = 1'b0;
    check_eq("stray_yumi", {cmd_ready_o, resp_v_o}, 2'b10);

    run_txn(1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b1, 6'h14, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0, 2'b00, 32'h0, 1);
    run_txn(1'b0, 6'h08, 32'h0, 4'h0, 0, 0, 0, 2, 2'b10, 32'h12345678, 0);
    run_txn(1'b1, 6'h20, 32'hA5A55A5A, 4'hC, 0, 2, 0, 1, 2'b11, 32'h0, 5);
    run_txn(1'b0, 6'h3C, 32'h0, 4'h0, 1, 1, 1, 0, 2'b01, 32'h0BADCAFE, 2);
    run_txn(1'b0, 6'h04, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h00C0FFEE, 0);

    send_cmd(1'b1, 6'h18, 32'h11112222, 4'hF);
    @(negedge aclk);
    check_eq("awvalid_before_reset", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    #2 aresetn = 1'b0;
    #1 check_eq("async_reset_outputs",
                {cmd_ready_o, resp_v_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                 m_axi_arvalid, m_axi_rready}, '0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check_eq("abandoned_quiet",
               {resp_v_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, '0);
    end
    check_eq("ready_after_midreset", cmd_ready_o, 1);
    slave_idle();
    run_txn(1'b1, 6'h18, 32'h33334444, 4'h5, 0, 0, 0, 0, 2'b00, 32'h0, 0);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
